sisc_ctrl: RTL and testbench

Multi-cycle control unit for the SISC processor. Sequences every instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and resolves conditional branches against the status register. It drives the PC, instruction register, register file, data memory and the ALU's `alu_op` override lines. It sits directly upstream of the ALU; its only inputs are the IR fields and the status register output.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_ctrl_br_cond.sv | 30 +++
 rtl/sisc_ctrl.sv | 114 +++++++++++
 tb/tb_sisc_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control unit: opcodes, sequencer states and alu_op codes.
// Imported by the control unit top and its branch-condition helper.
package sisc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_ADI = 4'd2;
    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;
    localparam logic [3:0] OP_LOD = 4'd8;
    localparam logic [3:0] OP_STR = 4'd9;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam logic [1:0] ALU_REG    = 2'b00;
    localparam logic [1:0] ALU_NOSTAT = 2'b10;
    localparam logic [1:0] ALU_IMM    = 2'b11;

    // Instructions whose second ALU operand is the sign-extended immediate.
    function automatic logic uses_imm(input logic [3:0] op);
        return (op == OP_ADI) || (op == OP_LOD) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/sisc_ctrl_br_cond.sv
// Branch resolution: decides whether a branch opcode is taken against the status
// flags and whether its target is absolute or PC-relative.
module br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken,
    output logic       br_sel
);

    logic hit;

    // mm = 0 never hits, so BRA/BRR never branch and BNE/BNR always do.
    assign hit = |(mm & stat);

    always_comb begin
        taken  = 1'b0;
        br_sel = 1'b0;
        case (opcode)
            OP_BRA: begin taken = hit;  br_sel = 1'b1; end
            OP_BRR: begin taken = hit;  br_sel = 1'b0; end
            OP_BNE: begin taken = !hit; br_sel = 1'b1; end
            OP_BNR: begin taken = !hit; br_sel = 1'b0; end
            default: begin taken = 1'b0; br_sel = 1'b0; end
        endcase
    end

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control unit: five-state instruction sequencer (plus START/HALT)
// with outputs decoded combinationally from the registered state and the IR fields.
module sisc_ctrl
    import sisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic [1:0] alu_op,
    output logic       ir_load,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       br_sel,
    output logic       pc_rst,
    output logic       mm_sel,
    output logic       dm_we,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       halted
);

    state_t state_q, state_d;
    logic   br_taken;
    logic   br_abs;
    logic   imm_sel;

    br_cond u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (br_taken),
        .br_sel (br_abs)
    );

    assign imm_sel = uses_imm(opcode);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state_q <= ST_START;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        // bit1 keeps the status register frozen outside EXECUTE; bit0 keeps
        // the re-latched ALU result stable through MEM and WRITEBACK.
        alu_op   = {1'b1, imm_sel};
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        mm_sel   = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
                pc_rst  = 1'b1;
                alu_op  = ALU_NOSTAT;
            end
            ST_FETCH: begin
                state_d  = ST_DECODE;
                ir_load  = 1'b1;
                pc_write = 1'b1;
                alu_op   = ALU_NOSTAT;
            end
            ST_DECODE: begin
                state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = br_abs;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_MEM;
                if (opcode == OP_ALU) alu_op = ALU_REG;
                else if (imm_sel)     alu_op = ALU_IMM;
                else                  alu_op = ALU_NOSTAT;
            end
            ST_MEM: begin
                state_d = ST_WRITEBACK;
                if (opcode == OP_LOD) begin
                    mm_sel = 1'b1;
                end else if (opcode == OP_STR) begin
                    mm_sel = 1'b1;
                    dm_we  = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                if ((opcode == OP_ALU) || (opcode == OP_ADI)) begin
                    rf_we = 1'b1;
                end else if (opcode == OP_LOD) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_START;
                alu_op  = ALU_NOSTAT;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Directed bench for sisc_ctrl: walks each instruction class through its five
// cycles and compares the full output vector against hand-computed values.
module tb_sisc_ctrl;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic [1:0] alu_op;
    logic       ir_load, pc_write, pc_sel, br_sel, pc_rst;
    logic       mm_sel, dm_we, rf_we, wb_sel, halted;

    int tests_run;
    int tests_failed;

    // {alu_op[1:0], ir_load, pc_write, pc_sel, br_sel, pc_rst, mm_sel, dm_we, rf_we, wb_sel, halted}
    logic [11:0] outs;
    assign outs = {alu_op, ir_load, pc_write, pc_sel, br_sel, pc_rst,
                   mm_sel, dm_we, rf_we, wb_sel, halted};

    localparam logic [11:0] V_RESET = 12'h820;
    localparam logic [11:0] V_FETCH = 12'hB00;

    sisc_ctrl dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .alu_op   (alu_op),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .pc_rst   (pc_rst),
        .mm_sel   (mm_sel),
        .dm_we    (dm_we),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_f  = 1'b0;
        opcode = 4'd0;
        mm     = 4'd0;
        stat   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== V_RESET) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, outs, V_RESET);
            end
        end
        rst_f = 1'b1;
        #1;
        tests_run++;
        if (outs !== V_RESET) begin
            tests_failed++;
            $display("FAIL reset_start: got %h expected %h", outs, V_RESET);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== V_FETCH) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got %h expected %h", outs, V_FETCH);
        end
    endtask

    // Entered at a FETCH negedge; leaves at the next FETCH negedge.
    task automatic test_alu();
        logic [11:0] exp_v [6];
        exp_v = '{V_FETCH, 12'h800, 12'h000, 12'h800, 12'h804, V_FETCH};
        opcode = 4'd1; mm = 4'd0; stat = 4'd0;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (outs !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL alu_cycle[%0d]: got %h expected %h", k, outs, exp_v[k]);
            end
            if (k < 5) @(negedge clk);
        end
    endtask

    task automatic test_branch(input logic [3:0] op, input logic [3:0] m,
                               input logic [3:0] s, input logic [11:0] exp_dec,
                               input string name);
        logic [11:0] exp_v [5];
        exp_v = '{V_FETCH, exp_dec, 12'h800, 12'h800, 12'h800};
        opcode = op; mm = m; stat = s;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (outs !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got %h expected %h", name, k, outs, exp_v[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lod_str();
        logic [11:0] lod_v [5];
        logic [11:0] str_v [5];
        int          we_count;
        lod_v = '{V_FETCH, 12'hC00, 12'hC00, 12'hC10, 12'hC06};
        str_v = '{V_FETCH, 12'hC00, 12'hC00, 12'hC18, 12'hC00};
        opcode = 4'd8; mm = 4'd0; stat = 4'd0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (outs !== lod_v[k]) begin
                tests_failed++;
                $display("FAIL lod_cycle[%0d]: got %h expected %h", k, outs, lod_v[k]);
            end
            @(negedge clk);
        end
        opcode   = 4'd9;
        we_count = 0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (outs !== str_v[k]) begin
                tests_failed++;
                $display("FAIL str_cycle[%0d]: got %h expected %h", k, outs, str_v[k]);
            end
            if (dm_we === 1'b1) we_count++;
            @(negedge clk);
        end
        tests_run++;
        if (we_count != 1) begin
            tests_failed++;
            $display("FAIL str_dm_we_count: got %0d expected 1", we_count);
        end
    endtask

    task automatic test_halt();
        opcode = 4'd15; mm = 4'd0; stat = 4'd0;
        tests_run++;
        if (outs !== V_FETCH) begin
            tests_failed++;
            $display("FAIL hlt_fetch: got %h expected %h", outs, V_FETCH);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== 12'h800) begin
            tests_failed++;
            $display("FAIL hlt_decode: got %h expected %h", outs, 12'h800);
        end
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== 12'h801) begin
                tests_failed++;
                $display("FAIL hlt_hold[%0d]: got %h expected %h", i, outs, 12'h801);
            end
        end
        rst_f = 1'b0;
        #1;
        tests_run++;
        if (outs !== V_RESET) begin
            tests_failed++;
            $display("FAIL hlt_reset: got %h expected %h", outs, V_RESET);
        end
        @(negedge clk);
        rst_f = 1'b1;
        #1;
        tests_run++;
        if (outs !== V_RESET) begin
            tests_failed++;
            $display("FAIL hlt_restart_start: got %h expected %h", outs, V_RESET);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== V_FETCH) begin
            tests_failed++;
            $display("FAIL hlt_restart_fetch: got %h expected %h", outs, V_FETCH);
        end
    endtask

    task automatic test_mid_reset();
        opcode = 4'd9; mm = 4'd0; stat = 4'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (outs !== 12'hC18) begin
            tests_failed++;
            $display("FAIL midrst_str_mem: got %h expected %h", outs, 12'hC18);
        end
        #2 rst_f = 1'b0;
        #1;
        tests_run++;
        if (dm_we !== 1'b0 || outs !== V_RESET) begin
            tests_failed++;
            $display("FAIL midrst_async_drop: got %h expected %h", outs, V_RESET);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== V_RESET) begin
            tests_failed++;
            $display("FAIL midrst_held: got %h expected %h", outs, V_RESET);
        end
        rst_f = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs !== V_FETCH) begin
            tests_failed++;
            $display("FAIL midrst_restart_fetch: got %h expected %h", outs, V_FETCH);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu();
        test_branch(4'd4, 4'b0001, 4'b0001, 12'h9C0, "bra_taken");
        test_branch(4'd4, 4'b0001, 4'b0000, 12'h800, "bra_not_taken");
        test_branch(4'd7, 4'b0000, 4'b1111, 12'h980, "bnr_mm0_taken");
        test_branch(4'd5, 4'b0010, 4'b0010, 12'h980, "brr_taken");
        test_branch(4'd6, 4'b0100, 4'b0100, 12'h800, "bne_not_taken");
        test_lod_str();
        test_halt();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
